// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with stored targets and ID-stage redirect.
// Optional tag storage/compare is enabled by defining BRANCH_PREDICTOR_TAG_EN.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [15:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic        valid_q  [ENTRIES];
    logic [29:0] target_q [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];
`ifdef BRANCH_PREDICTOR_TAG_EN
    logic [TAG_W-1:0] tag_q [ENTRIES];
`endif

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic                rd_hit;
    logic                wr_hit;
    logic [1:0]          ctr_next;

    assign rd_idx = if_pc[IDX_BITS+1:2];
    assign wr_idx = res_pc[IDX_BITS+1:2];

`ifdef BRANCH_PREDICTOR_TAG_EN
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == if_pc[31:IDX_BITS+2]);
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == res_pc[31:IDX_BITS+2]);
`else
    // Without tags, any valid entry is a hit and aliasing branches share it.
    assign rd_hit = valid_q[rd_idx];
    assign wr_hit = valid_q[wr_idx];
`endif

    // Lookup reads the registered table only, so a same-cycle write is not bypassed.
    assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
    assign pred_target = pred_taken ? {target_q[rd_idx], 2'b00} : if_pc + 32'd4;

    assign mispredict  = res_valid &&
                         ((res_taken != id_pred_taken) ||
                          (res_taken && (res_target != id_pred_target)));
    assign redirect_pc = (mispredict && res_taken) ? res_target : res_pc + 32'd4;

    always_comb begin
        ctr_next = ctr_q[wr_idx];
        if (res_taken) begin
            if (ctr_q[wr_idx] != 2'b11) ctr_next = ctr_q[wr_idx] + 2'b01;
        end else begin
            if (ctr_q[wr_idx] != 2'b00) ctr_next = ctr_q[wr_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
`ifdef BRANCH_PREDICTOR_TAG_EN
                tag_q[i]    <= '0;
`endif
            end
        end else if (res_valid) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_next;
                if (res_taken) target_q[wr_idx] <= res_target[31:2];
            end else if (res_taken) begin
                valid_q[wr_idx]  <= 1'b1;
                target_q[wr_idx] <= res_target[31:2];
                ctr_q[wr_idx]    <= 2'b10;
`ifdef BRANCH_PREDICTOR_TAG_EN
                tag_q[wr_idx]    <= res_pc[31:IDX_BITS+2];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt <= 16'd0;
        end else if (mispredict && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a behavioural table model.
// Honours BRANCH_PREDICTOR_TAG_EN in the same way as the design.
module tb_branch_predictor;

    localparam int IDX_BITS = 4;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] miss_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .res_target(res_target), .id_pred_taken(id_pred_taken),
        .id_pred_target(id_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .miss_cnt(miss_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one record per table slot, held as plain integers.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_target[ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_miss;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned upper(input logic [31:0] pc);
        return pc >> (IDX_BITS + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_TAG_EN
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == upper(pc));
`else
        return m_valid[slot(pc)];
`endif
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_pred(pc) ? m_target[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'd0; m_ctr[i] = 1;
        end
        m_miss = 0;
    endtask

    task automatic m_train(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        int s;
        s = slot(pc);
        if (m_hit(pc)) begin
            if (t) begin
                m_ctr[s]    = (m_ctr[s] >= 3) ? 3 : m_ctr[s] + 1;
                m_target[s] = tgt & 32'hFFFF_FFFC;
            end else begin
                m_ctr[s] = (m_ctr[s] <= 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (t) begin
            m_valid[s] = 1'b1; m_tag[s] = upper(pc);
            m_target[s] = tgt & 32'hFFFF_FFFC; m_ctr[s] = 2;
        end
    endtask

    // One cycle: drive, check combinational outputs, clock, advance the model.
    task automatic step(input logic rv, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic ipt, input logic [31:0] iptg,
                        input logic [31:0] fpc, input logic rst);
        bit          exp_mp;
        logic [31:0] exp_rd;
        reset = rst; res_valid = rv; res_pc = pc; res_taken = t; res_target = tgt;
        id_pred_taken = ipt; id_pred_target = iptg; if_pc = fpc;
        #1;
        exp_mp = rv && ((t != ipt) || (t && (tgt != iptg)));
        exp_rd = (exp_mp && t) ? tgt : pc + 32'd4;
        check("pred_taken", {31'd0, pred_taken}, {31'd0, m_pred(fpc)});
        check("pred_target", pred_target, m_next(fpc));
        check("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
        check("redirect_pc", redirect_pc, exp_rd);
        check("miss_cnt", {16'd0, miss_cnt}, m_miss);
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (exp_mp && m_miss < 65535) m_miss++;
            if (rv) m_train(pc, t, tgt);
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_target();
        return 32'h100 * $urandom_range(1, 4);
    endfunction

    initial begin
        logic [31:0] pc, fpc, tgt, iptg;
        logic        t, ipt;
        reset = 1'b1; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
        id_pred_taken = 1'b0; id_pred_target = '0; if_pc = 32'h40;
        repeat (2) @(posedge clk);
        m_reset();
        #1;

        // Reset state, first allocation and the counter walk for PC 0x40.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b0);
        step(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 32'h40, 1'b0);
        check("alloc_pred_target", pred_target, 32'h100);
        check("alloc_miss_cnt", {16'd0, miss_cnt}, 32'd1);
        repeat (3) step(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 32'h40, 1'b0);
        repeat (4) step(1'b1, 32'h40, 1'b0, 32'h100, m_pred(32'h40), m_next(32'h40), 32'h40, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40, 1'b0);
        check("walk_not_taken", {31'd0, pred_taken}, 32'd0);

        // Retrain, then a taken branch whose piped target is wrong.
        repeat (2) step(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 32'h40, 1'b0);
        step(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h104, 32'h40, 1'b0);
        step(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 32'h440, 1'b0);
`ifdef BRANCH_PREDICTOR_TAG_EN
        check("alias_0x440", {31'd0, pred_taken}, 32'd0);
`else
        check("alias_0x440", pred_target, 32'h100);
`endif

        // Reset wins over a concurrent training request.
        step(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 32'h80, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h80, 1'b0);

        for (int i = 0; i < 400; i++) begin
            pc  = 32'($urandom_range(0, 127)) << 2;
            fpc = ($urandom_range(0, 3) == 0) ? pc : 32'($urandom_range(0, 127)) << 2;
            t   = 1'($urandom_range(0, 1));
            tgt = rnd_target();
            if ($urandom_range(0, 3) != 0) begin
                ipt = m_pred(pc); iptg = m_next(pc);
            end else begin
                ipt = 1'($urandom_range(0, 1)); iptg = rnd_target();
            end
            step(1'($urandom_range(0, 4) != 0), pc, t, tgt, ipt, iptg, fpc,
                 1'($urandom_range(0, 99) == 0));
        end

        // Counter saturation under a long run of mispredicts.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        reset = 1'b0; res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1;
        res_target = 32'h100; id_pred_taken = 1'b0; id_pred_target = 32'h44;
        repeat (65540) @(posedge clk);
        #1;
        check("miss_cnt_sat", {16'd0, miss_cnt}, 32'h0000_FFFF);
        res_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
